// File: rtl/vram_arbiter.sv
// vram_arbiter: video-priority arbiter for a single-port synchronous 16-bit VRAM, one access per clock.
// Define VRAM_ARB_STATS_EN to add the saturating cpu_stall_cnt output.
module vram_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W:1]   vid_addr,
  output logic [15:0]       vid_dout,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W:1]   cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic [1:0]        cpu_be,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W:1]   ram_addr,
  output logic              ram_we,
  output logic [1:0]        ram_be,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ACK   = 2'd1,
    RD_WAIT1 = 2'd2,
    RD_WAIT2 = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       cpu_grant;
  logic       rd_done;
  logic       rd_ack;
  logic [1:0] vid_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_grant = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && !vid_req) begin
          cpu_grant = 1'b1;
          state_nxt = cpu_we ? WR_ACK : RD_WAIT1;
        end
      end
      WR_ACK:   state_nxt = IDLE;
      RD_WAIT1: state_nxt = RD_WAIT2;
      RD_WAIT2: begin
        rd_done   = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Write ack comes straight from the state; read ack is registered with the data.
  assign cpu_ack = (state == WR_ACK) || rd_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_be   <= 2'b00;
      ram_din  <= 16'h0000;
    end else if (vid_req) begin
      ram_addr <= vid_addr;
      ram_we   <= 1'b0;
      ram_be   <= 2'b11;
    end else if (cpu_grant) begin
      ram_addr <= cpu_addr;
      ram_we   <= cpu_we;
      ram_be   <= cpu_be;
      ram_din  <= cpu_din;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  // Tag bit 1 lines up with the RAM returning the word fetched for the video slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_tag   <= 2'b00;
      vid_valid <= 1'b0;
      vid_dout  <= 16'h0000;
    end else begin
      vid_tag   <= {vid_tag[0], vid_req};
      vid_valid <= vid_tag[1];
      if (vid_tag[1]) begin
        vid_dout <= ram_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack   <= 1'b0;
      cpu_dout <= 16'h0000;
    end else begin
      rd_ack <= rd_done;
      if (rd_done) begin
        cpu_dout <= ram_dout;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_stall_cnt <= 16'h0000;
    end else if ((state == IDLE) && cpu_req && vid_req && (cpu_stall_cnt != 16'hFFFF)) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-requester arbiter for the single-port 16-bit video RAM: the raster fetch path reads one word per fetch strobe, and the CPU bus performs byte-maskable reads/writes in the remaining slots. Video has absolute priority, so raster fetches always complete with fixed latency and display output never tears. The arbiter sits between the video generator, the CPU memory decoder and the synchronous-read video RAM, and issues one RAM access per clock.

## Interface
- ADDR_W, 14: word address width; addresses are [ADDR_W:1] (16-bit words).
- clk  in  1  system/pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video fetch strobe; one read per high cycle.
- vid_addr  in  ADDR_W  video word address, sampled with vid_req.
- vid_dout  out  16  video read data, held between fetches.
- vid_valid  out  1  one-cycle pulse: vid_dout updated.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU word address; stable while cpu_req.
- cpu_din  in  16  CPU write data.
- cpu_be  in  2  byte enables ([1] = bits 15:8, [0] = bits 7:0).
- cpu_dout  out  16  CPU read data, valid with cpu_ack on reads.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered write strobe.
- ram_be  out  2  registered byte enables.
- ram_din  out  16  registered write data.
- ram_dout  in  16  RAM read data; valid the cycle after the RAM samples ram_addr.

## Operation
- Each rising edge grants at most one slot. Priority: vid_req, then a pending CPU request.
- Video grant: ram_addr <= vid_addr, ram_we <= 0, ram_be <= 2'b11; a 2-stage video tag pipeline is set.
- CPU FSM states: IDLE, WR_ACK, RD_WAIT1, RD_WAIT2.
- IDLE: if cpu_req && !vid_req: drive ram_* from cpu_*; ram_we <= cpu_we; go to WR_ACK (write) or RD_WAIT1 (read). If vid_req also high, CPU stays in IDLE (stalled) and retries next edge.
- WR_ACK: cpu_ack = 1 for this cycle; next state IDLE.
- RD_WAIT1 -> RD_WAIT2 unconditionally; at the end of RD_WAIT2, cpu_dout <= ram_dout, cpu_ack <= 1, state <= IDLE.
- ram_we is high for exactly one cycle per write; otherwise 0. ram_addr, ram_be and ram_din hold their last values in unused slots.
- In-flight CPU reads and video reads never collide: the RAM is pipelined, one address per slot, and each read carries its own tag.
- cpu_req still high in the cycle cpu_ack is high is treated as a new back-to-back request. The requester drops cpu_req in that cycle to avoid this.
- cpu_req changes while not in IDLE are ignored.
- Reset mid-operation clears the FSM and tag pipelines. No ack or valid is produced for dropped accesses.

## Timing
- Reset values: ram_addr 0, ram_we 0, ram_be 0, ram_din 0, vid_dout 0, vid_valid 0, cpu_dout 0, cpu_ack 0, FSM IDLE.
- Video read: vid_req in cycle N -> vid_valid and new vid_dout in cycle N+3. Fixed latency, independent of CPU activity.
- CPU write: granted at end of cycle N -> ram_we high in cycle N+1, cpu_ack in cycle N+1.
- CPU read: granted at end of cycle N -> cpu_ack with cpu_dout in cycle N+3.
- Back-to-back vid_req every cycle is legal. The CPU is then stalled indefinitely; the raster source guarantees gaps (at most one fetch per 4 clocks).

## Configuration
- VRAM_ARB_STATS_EN defined:
  - adds output cpu_stall_cnt [15:0];
  - counts cycles in which cpu_req is pending in IDLE but denied because of vid_req;
  - saturates at 16'hFFFF;
  - cleared by reset_n.
- VRAM_ARB_STATS_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold reset_n = 0 with random inputs -> all outputs 0; release, with no requests for 10 cycles -> ram_we stays 0, no ack or valid.
- Video read: ram_dout model returns the address; vid_req = 1 at cycle 5 with vid_addr = 14'h1234 -> ram_addr = 14'h1234 at cycle 6; vid_valid = 1 and vid_dout = 16'h1234 at cycle 8 only.
- CPU write: cpu_req/cpu_we = 1, cpu_addr = 14'h0100, cpu_din = 16'hA55A, cpu_be = 2'b10 -> ram_we = 1 and ram_be = 2'b10 for exactly one cycle, cpu_ack in the same cycle; RAM model high byte = 8'hA5, low byte unchanged.
- Collision: cpu_req read to 14'h0200 and vid_req (14'h0300) in the same cycle -> video issued first, CPU issued the next cycle; vid_valid at N+3, cpu_ack with cpu_dout = 16'h0200 at N+4; with macro, cpu_stall_cnt = 1.
- Raster load: vid_req every 4th cycle for 1000 cycles with continuous random CPU traffic -> every vid_valid arrives at exactly +3 cycles; all CPU reads return correct data; no lost or duplicate cpu_ack.
- Reset mid-read: assert reset_n = 0 in RD_WAIT1 -> no cpu_ack after release; the next request completes normally.
